// File: rtl/ariane_pkg.sv
// Shared core types: exception record, writeback entry and writeback sizing.
package ariane_pkg;

    localparam int unsigned NR_WB_PORTS   = 4;
    localparam int unsigned TRANS_ID_BITS = 2;

    // 129-bit exception record: {cause, tval, valid}.
    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    // One writeback entry as produced by a functional unit.
    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              result;
        exception_t               ex;
    } wb_entry_t;

endpackage

// File: rtl/rr_arb_lock.sv
// Round-robin priority picker with a grant lock.
// While the previous cycle asked for a lock, the previously issued grant is
// replayed so the downstream sees a stable choice during back-pressure.
module rr_arb_lock #(
    parameter  int unsigned NR_REQ = 4,
    localparam int unsigned IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NR_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]  rr_ptr_i,
    input  logic              lock_i,
    output logic [NR_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]  gnt_idx_o
);

    logic             lock_q;
    logic [IDX_W-1:0] gnt_q;
    logic [IDX_W-1:0] pick_idx;
    logic             found;
    int               cand;

    // Scan rr_ptr, rr_ptr+1, ... modulo NR_REQ and take the first request.
    always_comb begin
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < int'(NR_REQ); k++) begin
            cand = int'(rr_ptr_i) + k;
            if (cand >= int'(NR_REQ)) begin
                cand = cand - int'(NR_REQ);
            end
            if (!found && req_i[IDX_W'(cand)]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    assign gnt_idx_o = lock_q ? gnt_q : pick_idx;

    generate
        for (genvar gi = 0; gi < int'(NR_REQ); gi++) begin : g_oh
            assign gnt_oh_o[gi] = req_i[gi] && (gnt_idx_o == IDX_W'(gi));
        end
    endgenerate

    // Remember the issued grant and whether it must be replayed next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
            gnt_q  <= '0;
        end else begin
            lock_q <= lock_i;
            gnt_q  <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry buffer per functional unit, drained
// round-robin into the single scoreboard writeback port.
module wb_arbiter
    import ariane_pkg::*;
#(
    parameter  int unsigned NR_REQ = NR_WB_PORTS,
    parameter  int unsigned TID_W  = TRANS_ID_BITS,
    localparam int unsigned IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [NR_REQ-1:0] req_valid_i,
    output logic [NR_REQ-1:0] req_ready_o,
    input  logic [TID_W-1:0]  req_trans_id_i [NR_REQ],
    input  logic [63:0]       req_result_i   [NR_REQ],
    input  exception_t        req_ex_i       [NR_REQ],
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [TID_W-1:0]  wb_trans_id_o,
    output logic [63:0]       wb_result_o,
    output exception_t        wb_ex_o,
    output logic [IDX_W-1:0]  wb_port_o
);

    // Same layout as wb_entry_t, but sized by this instance's TID_W.
    typedef struct packed {
        logic [TID_W-1:0] trans_id;
        logic [63:0]      result;
        exception_t       ex;
    } entry_t;

    logic [NR_REQ-1:0] buf_valid_q;
    logic [NR_REQ-1:0] buf_valid_d;
    entry_t            buf_data_q [NR_REQ];
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;

    logic [IDX_W-1:0]  gnt_idx;
    logic [NR_REQ-1:0] gnt_oh;
    logic              wb_valid;
    logic              pop;
    logic [NR_REQ-1:0] push;
    entry_t            gnt_entry;

    // Flush hides the buffers from the scoreboard in the same cycle.
    assign wb_valid = (|buf_valid_q) && !flush_i;
    assign pop      = wb_valid && wb_ready_i;

    rr_arb_lock #(
        .NR_REQ (NR_REQ)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (buf_valid_q),
        .rr_ptr_i  (rr_ptr_q),
        .lock_i    (wb_valid && !wb_ready_i),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    // With nothing buffered the picker returns index 0, so data comes from buf 0.
    assign gnt_entry     = buf_data_q[gnt_idx];
    assign wb_valid_o    = wb_valid;
    assign wb_trans_id_o = gnt_entry.trans_id;
    assign wb_result_o   = gnt_entry.result;
    assign wb_ex_o       = gnt_entry.ex;
    assign wb_port_o     = gnt_idx;

    generate
        for (genvar gi = 0; gi < int'(NR_REQ); gi++) begin : g_port
            // A full buffer frees up in the same cycle it is popped, allowing streaming.
            assign req_ready_o[gi] = !flush_i && (!buf_valid_q[gi] || (pop && gnt_oh[gi]));
            assign push[gi]        = req_valid_i[gi] && req_ready_o[gi];

            // Next valid bit: a push wins over the pop of the same entry.
            always_comb begin
                buf_valid_d[gi] = buf_valid_q[gi];
                if (flush_i) begin
                    buf_valid_d[gi] = 1'b0;
                end else if (push[gi]) begin
                    buf_valid_d[gi] = 1'b1;
                end else if (pop && gnt_oh[gi]) begin
                    buf_valid_d[gi] = 1'b0;
                end
            end

            // Per-port buffer storage.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    buf_valid_q[gi] <= 1'b0;
                    buf_data_q[gi]  <= '0;
                end else begin
                    buf_valid_q[gi] <= buf_valid_d[gi];
                    if (push[gi]) begin
                        buf_data_q[gi] <= '{trans_id: req_trans_id_i[gi],
                                            result:   req_result_i[gi],
                                            ex:       req_ex_i[gi]};
                    end
                end
            end
        end
    endgenerate

    // Priority moves past the port just written back; only pops move it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifndef SYNTHESIS
    logic              stall_q;
    logic [TID_W-1:0]  stall_tid_q;
    logic [63:0]       stall_res_q;
    logic [IDX_W-1:0]  stall_port_q;
    logic [NR_REQ-1:0] hold_q;

    // Capture what must stay stable and which requests are still pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            stall_q <= wb_valid && !wb_ready_i;
            hold_q  <= flush_i ? '0 : (req_valid_i & ~req_ready_o);
        end
        stall_tid_q  <= wb_trans_id_o;
        stall_res_q  <= wb_result_o;
        stall_port_q <= wb_port_o;
    end

    // Protocol checks: stable stalled output, held requests, unique trans_ids.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (stall_q) begin
                assert (flush_i || (wb_valid_o && wb_trans_id_o == stall_tid_q &&
                                    wb_result_o == stall_res_q && wb_port_o == stall_port_q));
            end
            assert ((req_valid_i & hold_q) == hold_q);
            for (int i = 0; i < int'(NR_REQ); i++) begin
                for (int j = i + 1; j < int'(NR_REQ); j++) begin
                    assert (!(buf_valid_q[i] && buf_valid_q[j] &&
                              buf_data_q[i].trans_id == buf_data_q[j].trans_id));
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single push, round-robin order, stall lock,
// streaming, flush and reset-while-stalled.
module tb_wb_arbiter;
    import ariane_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [1:0]  req_tid [4];
    logic [63:0] req_res [4];
    exception_t  req_ex  [4];
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_tid;
    logic [63:0] wb_result;
    exception_t  wb_ex;
    logic [1:0]  wb_port;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_trans_id_i (req_tid),
        .req_result_i   (req_res),
        .req_ex_i       (req_ex),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_trans_id_o  (wb_tid),
        .wb_result_o    (wb_result),
        .wb_ex_o        (wb_ex),
        .wb_port_o      (wb_port)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_wb(input string tag, input logic v, input int port, input int tid,
                             input logic [63:0] res);
        check({tag, ".valid"}, 64'(wb_valid), 64'(v));
        if (v) begin
            check({tag, ".port"}, 64'(wb_port), 64'(port));
            check({tag, ".tid"}, 64'(wb_tid), 64'(tid));
            check({tag, ".result"}, wb_result, res);
        end
        $display("wb %s valid=%0b port=%0d tid=%0d result=%0h", tag, wb_valid, wb_port, wb_tid, wb_result);
    endtask

    task automatic push(input int p, input int tid, input logic [63:0] res);
        req_valid[p] = 1'b1;
        req_tid[p]   = 2'(tid);
        req_res[p]   = res;
        req_ex[p]    = '0;
    endtask

    task automatic idle();
        req_valid = 4'b0000;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        wb_ready  = 1'b1;
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req_tid[i] = '0;
            req_res[i] = '0;
            req_ex[i]  = '0;
        end
        repeat (2) @(posedge clk);
        step();
        rst = 1'b0;

        // Reset state
        check("rst.ready", 64'(req_ready), 64'hf);
        expect_wb("rst", 1'b0, 0, 0, 64'h0);
        check("rst.tid", 64'(wb_tid), 64'h0);
        check("rst.result", wb_result, 64'h0);
        check("rst.port", 64'(wb_port), 64'h0);
        check("rst.exv", 64'(wb_ex.valid), 64'h0);

        // Single push on port 2, carrying an exception
        push(2, 1, 64'hDEAD_BEEF);
        req_ex[2] = '{cause: 64'd5, tval: 64'h1234, valid: 1'b1};
        step();
        idle();
        expect_wb("single", 1'b1, 2, 1, 64'hDEAD_BEEF);
        check("single.exv", 64'(wb_ex.valid), 64'h1);
        check("single.cause", wb_ex.cause, 64'd5);
        check("single.tval", wb_ex.tval, 64'h1234);
        step();
        expect_wb("single.done", 1'b0, 0, 0, 64'h0);

        // rr_ptr is now 3: port 3 beats port 0
        push(0, 0, 64'h10);
        push(3, 3, 64'h13);
        step();
        idle();
        expect_wb("rr3.a", 1'b1, 3, 3, 64'h13);
        step();
        expect_wb("rr3.b", 1'b1, 0, 0, 64'h10);
        step();
        expect_wb("rr3.done", 1'b0, 0, 0, 64'h0);

        // All four ports from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) push(p, p, 64'h200 + 64'(p));
        step();
        idle();
        for (int p = 0; p < 4; p++) begin
            expect_wb($sformatf("all4.%0d", p), 1'b1, p, p, 64'h200 + 64'(p));
            step();
        end
        expect_wb("all4.done", 1'b0, 0, 0, 64'h0);

        // Back-pressure with a higher-priority late arrival on port 0
        wb_ready = 1'b0;
        push(1, 1, 64'h301);
        push(3, 3, 64'h303);
        step();
        idle();
        for (int c = 0; c < 5; c++) begin
            expect_wb($sformatf("stall.%0d", c), 1'b1, 1, 1, 64'h301);
            check("stall.ready1", 64'(req_ready[1]), 64'h0);
            check("stall.ready3", 64'(req_ready[3]), 64'h0);
            if (c >= 2) check("stall.ready0", 64'(req_ready[0]), 64'h0);
            if (c == 1) push(0, 0, 64'h300);
            else        idle();
            step();
        end
        wb_ready = 1'b1;
        #1;
        check("release.ready1", 64'(req_ready[1]), 64'h1);
        expect_wb("release.a", 1'b1, 1, 1, 64'h301);
        step();
        expect_wb("release.b", 1'b1, 3, 3, 64'h303);
        step();
        expect_wb("release.c", 1'b1, 0, 0, 64'h300);
        step();
        expect_wb("release.done", 1'b0, 0, 0, 64'h0);

        // Streaming from port 0 (rr_ptr is 1)
        check("stream.ready0.start", 64'(req_ready[0]), 64'h1);
        push(0, 0, 64'd1000);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("stream.ready0.%0d", k), 64'(req_ready[0]), 64'h1);
            expect_wb($sformatf("stream.%0d", k), 1'b1, 0, (k - 1) % 4, 64'd1000 + 64'(k - 1));
            if (k < 8) push(0, k % 4, 64'd1000 + 64'(k));
            else       idle();
        end
        step();
        expect_wb("stream.done", 1'b0, 0, 0, 64'h0);

        // Flush with a simultaneous push on port 1 (rr_ptr is 1)
        wb_ready = 1'b0;
        push(0, 0, 64'h500);
        push(2, 2, 64'h502);
        step();
        idle();
        expect_wb("preflush", 1'b1, 2, 2, 64'h502);
        flush = 1'b1;
        push(1, 1, 64'h501);
        #1;
        check("flush.valid", 64'(wb_valid), 64'h0);
        check("flush.ready", 64'(req_ready), 64'h0);
        step();
        flush = 1'b0;
        idle();
        #1;
        check("postflush.valid", 64'(wb_valid), 64'h0);
        check("postflush.ready", 64'(req_ready), 64'hf);
        wb_ready = 1'b1;
        push(0, 0, 64'h510);
        push(2, 2, 64'h512);
        step();
        idle();
        expect_wb("postflush.a", 1'b1, 2, 2, 64'h512);
        step();
        expect_wb("postflush.b", 1'b1, 0, 0, 64'h510);
        step();
        expect_wb("postflush.done", 1'b0, 0, 0, 64'h0);

        // Reset while stalled with three full buffers (rr_ptr is 1)
        wb_ready = 1'b0;
        push(0, 0, 64'h600);
        push(1, 1, 64'h601);
        push(2, 2, 64'h602);
        step();
        idle();
        expect_wb("prerst.a", 1'b1, 1, 1, 64'h601);
        step();
        expect_wb("prerst.b", 1'b1, 1, 1, 64'h601);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_wb("midrst", 1'b0, 0, 0, 64'h0);
        check("midrst.ready", 64'(req_ready), 64'hf);
        wb_ready = 1'b1;
        push(0, 0, 64'h610);
        push(3, 3, 64'h613);
        step();
        idle();
        expect_wb("midrst.a", 1'b1, 0, 0, 64'h610);
        step();
        expect_wb("midrst.b", 1'b1, 3, 3, 64'h613);
        step();
        expect_wb("midrst.done", 1'b0, 0, 0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single scoreboard writeback port between NR_WB_PORTS functional units (LSU load, LSU store, ALU/branch, MULT/CSR).
- Each requester hands over {trans_id, result, exception} on a valid/ready handshake. The data is held in a one-entry per-port buffer and granted round-robin into the scoreboard.
- Sits between the EX-stage units and the scoreboard writeback input. Flushed on mispredict or exception.

Parameters:
- NR_REQ, default NR_WB_PORTS (4): number of requesting functional units.
- TID_W, default TRANS_ID_BITS (2): width of the transaction id.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  drop all buffered results.
- req_valid_i  in  NR_REQ  per-unit result valid.
- req_ready_o  out  NR_REQ  per-unit buffer can accept.
- req_trans_id_i  in  NR_REQ x TID_W  scoreboard entry id.
- req_result_i  in  NR_REQ x 64  result data.
- req_ex_i  in  NR_REQ x exception (129)  exception {cause, tval, valid}.
- wb_valid_o  out  1  writeback valid to the scoreboard.
- wb_ready_i  in  1  scoreboard accepts writeback.
- wb_trans_id_o  out  TID_W  granted trans_id.
- wb_result_o  out  64  granted result.
- wb_ex_o  out  exception  granted exception.
- wb_port_o  out  clog2(NR_REQ)  index of the granted requester (for debug/perf).

Behaviour:
- State:
  - buf_valid[NR_REQ] and buf_data[NR_REQ], where buf_data = {trans_id, result, ex}.
  - rr_ptr, clog2(NR_REQ) bits: the highest-priority port.
- Reset (rst_i sampled high at a clock edge):
  - buf_valid, rr_ptr and all buf_data are cleared to 0.
  - Outputs after reset: wb_valid_o=0, wb_* data=0, wb_port_o=0, req_ready_o=all 1s.
  - Reset mid-transfer discards the buffered results silently.
- Push: port i accepts when req_valid_i[i] && req_ready_o[i]; data is written into buf i at the clock edge.
- Grant selection (combinational):
  - Take the first i with buf_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NR_REQ.
  - wb_valid_o = |buf_valid. wb_* carry buf_data[grant]; wb_port_o = grant.
  - When wb_valid_o=0, the data outputs are don't-care but must be driven from buf 0 with no X.
- Pop: when wb_valid_o && wb_ready_i:
  - buf_valid[grant] clears.
  - rr_ptr <= grant+1, wrapping NR_REQ-1 -> 0.
  - rr_ptr changes only on a pop.
- Ready: req_ready_o[i] = !buf_valid[i] || (pop && grant==i).
  - This allows back-to-back one-per-cycle streaming from a single port.
  - A combinational path from wb_ready_i to req_ready_o is permitted.
- Simultaneous pop and push on the same port: the new data replaces the entry; buf_valid stays 1.
- Latency:
  - Push at edge N gives wb_valid_o in cycle N+1, so minimum latency is 1 cycle.
  - There is no combinational bypass from req_*_i to wb_*_o.
- Fairness: a port with buf_valid=1 is granted within at most NR_REQ pops.
- Stall: wb_ready_i=0 holds all buffers; the grant and wb_* stay stable while wb_valid_o=1, with no glitching and no re-arbitration.
  - New pushes into empty buffers may still arrive and may change the grant only if they have higher round-robin priority.
  - The implementation must keep the grant stable instead: lock the grant while wb_valid_o && !wb_ready_i.
- Flush:
  - flush_i=1 forces req_ready_o=0 and wb_valid_o=0 in the same cycle.
  - At the edge, all buf_valid clear. rr_ptr is unchanged.
  - flush_i has priority over any simultaneous push or pop.
- Exceptions: carried unmodified. An exception-valid entry is arbitrated like any other result, with no priority boost.
- Assertions (sim only):
  - No two valid buffers hold the same trans_id.
  - wb_* are stable while wb_valid_o && !wb_ready_i.
  - No req_valid_i is deasserted before its handshake completes.

Decomposition:
- Shared package (ariane_pkg) gets:
  - the existing exception struct;
  - a new wb_entry_t struct {trans_id, result, ex};
  - NR_WB_PORTS and TRANS_ID_BITS as the parameter defaults.
- One natural sub-module: rr_arb_lock, a round-robin priority picker with a grant lock. It takes a request vector, rr_ptr and lock, and returns a one-hot/index grant.
- The buffers and handshake stay in wb_arbiter.

Test Plan:
- Single port: port 2 pushes tid=1, result=64'hDEAD_BEEF with wb_ready_i=1 -> next cycle wb_valid_o=1, wb_trans_id_o=1, wb_result_o=DEADBEEF, wb_port_o=2; rr_ptr becomes 3.
- All four ports push in the same cycle (tids 0..3), wb_ready_i=1, from reset -> grants ports 0,1,2,3 on consecutive cycles; wb_valid_o drops in the 5th cycle.
- Back-pressure: wb_ready_i=0 for 5 cycles with ports 1 and 3 buffered -> wb_port_o stays 1 with stable data; req_ready_o[1]=req_ready_o[3]=0; after release, port 1 is popped then port 3.
- Streaming: port 0 holds req_valid_i for 8 cycles while port 1 is idle, wb_ready_i=1 -> 8 writebacks on 8 consecutive cycles (the first at latency 1) and req_ready_o[0] stays 1.
- Flush: ports 0 and 2 are buffered and flush_i is pulsed together with a new push on port 1 -> that cycle wb_valid_o=0, and the next cycle all buffers are empty (the port 1 push is dropped) and rr_ptr is unchanged.
- Reset mid-stall: 3 buffers full and wb_ready_i=0, then rst_i=1 for 1 cycle -> wb_valid_o=0, req_ready_o=4'b1111, and the next grant after a push to port 3 comes from rr_ptr=0.
